// File: rtl/pyrxscobufctrl.sv
// rtl/pyrxscobufctrl.sv - receive-side SCO ping-pong payload buffer controller
// Link controller fills one bank while the baseband state machine drains the other.

module sram256x32_1p #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          cs,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   din,
  output logic [31:0]   dout
);
  logic [31:0] r_mem [0:(1<<AW)-1];
  logic [31:0] r_dout;

  always_ff @(posedge clk) begin
    if (cs) begin
      if (we) r_mem[addr] <= din;
      else    r_dout      <= r_mem[addr];
    end
  end

  assign dout = r_dout;
endmodule

module pyrxscobufctrl #(
  parameter int BANK_AW = 7
) (
  input  logic             clk_6M,
  input  logic             rstz,
  input  logic             tsco_p,
  input  logic             lnctrl_sof,
  input  logic             lnctrl_wr,
  input  logic [31:0]      lnctrl_din,
  input  logic             bsm_rd,
  input  logic             bsm_ovf_clr,
  output logic             bsm_rdy,
  output logic             bsm_rvalid,
  output logic [31:0]      bsm_dout,
  output logic [BANK_AW:0] bsm_wcnt,
  output logic             bsm_empty,
  output logic             bsm_ovf
);
  localparam int PW = BANK_AW + 1;

  logic          r_wbank;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wcnt;
  logic          r_pending;
  logic          r_rvalid;
  logic [31:0]   r_dout;
  logic          r_ovf;

  logic [PW-1:0] w_ptr_eff;
  logic          w_wr_en;
  logic          w_wr_drop;
  logic [PW-1:0] w_wr_next;
  logic          w_empty;
  logic          w_accept;
  logic          w_issue;
  logic          w_cs;
  logic [PW-1:0] w_addr;
  logic [31:0]   w_sram_dout;

  // Pointer saturates at the bank size, so its MSB alone flags "bank full".
  assign w_ptr_eff = lnctrl_sof ? '0 : r_wr_ptr;
  assign w_wr_en   = lnctrl_wr & ~w_ptr_eff[BANK_AW];
  assign w_wr_drop = lnctrl_wr &  w_ptr_eff[BANK_AW];
  assign w_wr_next = w_wr_en ? w_ptr_eff + PW'(1) : w_ptr_eff;

  assign w_empty  = (r_rd_ptr == r_wcnt);
  assign w_accept = bsm_rd & ~r_pending & ~w_empty;
  assign w_issue  = (w_accept | r_pending) & ~w_wr_en;

  assign w_cs   = w_wr_en | w_issue;
  assign w_addr = w_wr_en ? {r_wbank, w_ptr_eff[BANK_AW-1:0]}
                          : {~r_wbank, r_rd_ptr[BANK_AW-1:0]};

  sram256x32_1p #(.AW(PW)) u_sram (
    .clk  (clk_6M),
    .cs   (w_cs),
    .we   (w_wr_en),
    .addr (w_addr),
    .din  (lnctrl_din),
    .dout (w_sram_dout)
  );

  always_ff @(posedge clk_6M) begin
    if (!rstz) begin
      r_wbank   <= 1'b0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_wcnt    <= '0;
      r_pending <= 1'b0;
      r_rvalid  <= 1'b0;
      r_dout    <= '0;
      r_ovf     <= 1'b0;
    end else begin
      r_wr_ptr <= tsco_p ? '0 : w_wr_next;
      if (tsco_p) begin
        r_wbank <= ~r_wbank;
        r_wcnt  <= w_wr_next;
      end
      if (tsco_p)       r_rd_ptr <= '0;
      else if (w_issue) r_rd_ptr <= r_rd_ptr + PW'(1);
      // A read issued on the swap cycle still completes; only a held one is lost.
      if (tsco_p || w_issue) r_pending <= 1'b0;
      else if (w_accept)     r_pending <= 1'b1;
      r_rvalid <= w_issue;
      if (r_rvalid) r_dout <= w_sram_dout;
      if (w_wr_drop)        r_ovf <= 1'b1;
      else if (bsm_ovf_clr) r_ovf <= 1'b0;
    end
  end

  assign bsm_rdy    = ~r_pending;
  assign bsm_rvalid = r_rvalid;
  assign bsm_dout   = r_rvalid ? w_sram_dout : r_dout;
  assign bsm_wcnt   = r_wcnt;
  assign bsm_empty  = w_empty;
  assign bsm_ovf    = r_ovf;
endmodule

// File: tb/tb_pyrxscobufctrl.sv
// tb/tb_pyrxscobufctrl.sv - scoreboard bench for pyrxscobufctrl
module tb_pyrxscobufctrl;
  logic        clk_6M = 1'b0;
  logic        rstz = 1'b0;
  logic        tsco_p = 1'b0;
  logic        lnctrl_sof = 1'b0;
  logic        lnctrl_wr = 1'b0;
  logic [31:0] lnctrl_din = '0;
  logic        bsm_rd = 1'b0;
  logic        bsm_ovf_clr = 1'b0;
  logic        bsm_rdy;
  logic        bsm_rvalid;
  logic [31:0] bsm_dout;
  logic [7:0]  bsm_wcnt;
  logic        bsm_empty;
  logic        bsm_ovf;

  pyrxscobufctrl dut (
    .clk_6M(clk_6M), .rstz(rstz), .tsco_p(tsco_p), .lnctrl_sof(lnctrl_sof),
    .lnctrl_wr(lnctrl_wr), .lnctrl_din(lnctrl_din), .bsm_rd(bsm_rd),
    .bsm_ovf_clr(bsm_ovf_clr), .bsm_rdy(bsm_rdy), .bsm_rvalid(bsm_rvalid),
    .bsm_dout(bsm_dout), .bsm_wcnt(bsm_wcnt), .bsm_empty(bsm_empty), .bsm_ovf(bsm_ovf)
  );

  always #5 clk_6M = ~clk_6M;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: two banks of stored words, counts and the read cursor.
  int        m_bank[2][128];
  int        m_wb, m_wcount, m_rcount, m_rp;
  bit        m_pend, m_ovf, m_rvalid, m_started;
  int        exp_q[$];

  function automatic void model_edge(input bit sof, input bit wr, input int din,
                                     input bit rd, input bit clr, input bit tsco, input bit rst);
    int  pos;
    bit  wrote, acc, iss;
    if (rst) begin
      m_wb = 0; m_wcount = 0; m_rcount = 0; m_rp = 0;
      m_pend = 0; m_ovf = 0; m_rvalid = 0;
      exp_q.delete();
      return;
    end
    pos = sof ? 0 : m_wcount;
    wrote = wr && (pos < 128);
    if (wrote) begin
      m_bank[m_wb][pos] = din;
      pos = pos + 1;
    end
    if (wr && !wrote) m_ovf = 1;
    else if (clr)     m_ovf = 0;
    acc = rd && !m_pend && (m_rp != m_rcount);
    iss = (acc || m_pend) && !wrote;
    m_rvalid = iss;
    if (iss) begin
      exp_q.push_back(m_bank[1 - m_wb][m_rp]);
      m_rp++;
      m_pend = 0;
    end else if (acc) begin
      m_pend = 1;
    end
    if (tsco) begin
      m_wb = 1 - m_wb;
      m_rcount = pos;
      m_wcount = 0;
      m_rp = 0;
      m_pend = 0;
    end else begin
      m_wcount = pos;
    end
  endfunction

  task automatic cyc(input bit sof, input bit wr, input logic [31:0] din,
                     input bit rd, input bit clr, input bit tsco, input bit rst);
    lnctrl_sof = sof; lnctrl_wr = wr; lnctrl_din = din; bsm_rd = rd;
    bsm_ovf_clr = clr; tsco_p = tsco; rstz = !rst;
    @(posedge clk_6M);
    model_edge(sof, wr, int'(din), rd, clr, tsco, rst);
    m_started = 1;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: compares DUT outputs with the model state away from the edge.
  always @(negedge clk_6M) begin
    if (m_started) begin
      chk("rvalid", {31'b0, bsm_rvalid}, {31'b0, m_rvalid});
      if (bsm_rvalid) begin
        if (exp_q.size() == 0) chk("unexpected_rvalid", 32'd1, 32'd0);
        else chk("rdata", bsm_dout, exp_q.pop_front());
      end
      chk("rdy", {31'b0, bsm_rdy}, {31'b0, !m_pend});
      chk("empty", {31'b0, bsm_empty}, {31'b0, m_rp == m_rcount});
      chk("wcnt", {24'b0, bsm_wcnt}, m_rcount);
      chk("ovf", {31'b0, bsm_ovf}, {31'b0, m_ovf});
    end
  end

  initial begin
    int gap, since;
    // Reset, then a swap with nothing written; read must be ignored.
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("reset_dout", bsm_dout, 32'h0);
    chk("reset_wcnt", {24'b0, bsm_wcnt}, 32'd0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    chk("rd_on_empty_no_rvalid", {31'b0, bsm_rvalid}, 32'd0);

    // Five words, swap, spaced read-back.
    cyc(1, 1, 32'hA000_0000, 0, 0, 0, 0);
    for (int i = 1; i < 5; i++) cyc(0, 1, 32'hA000_0000 + i, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    chk("wcnt_five", {24'b0, bsm_wcnt}, 32'd5);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 1, 0, 0, 0);
      chk("read_latency_one", {31'b0, bsm_rvalid}, 32'd1);
      idle(2);
    end
    chk("empty_after_drain", {31'b0, bsm_empty}, 32'd1);

    // Contention: read held behind three consecutive writes.
    for (int i = 0; i < 6; i++) cyc(0, 1, 32'hC000_0000 + i, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 32'hD000_0000 + i, 1, 0, 0, 0);
      chk("rdy_low_contended", {31'b0, bsm_rdy}, 32'd0);
    end
    idle(3);

    // Overflow and simultaneous overflow+clear.
    cyc(0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 130; i++) cyc(i == 0, 1, 32'hE000_0000 + i, 0, 0, 0, 0);
    chk("ovf_set", {31'b0, bsm_ovf}, 32'd1);
    cyc(0, 1, 32'hEEEE_EEEE, 0, 1, 0, 0);
    chk("ovf_set_beats_clr", {31'b0, bsm_ovf}, 32'd1);
    cyc(0, 0, 0, 0, 0, 1, 0);
    chk("wcnt_full", {24'b0, bsm_wcnt}, 32'd128);
    cyc(0, 0, 0, 0, 1, 0, 0);
    chk("ovf_cleared", {31'b0, bsm_ovf}, 32'd0);

    // Retransmit restarts the write pointer.
    for (int i = 0; i < 4; i++) cyc(0, 1, 32'hF000_0000 + i, 0, 0, 0, 0);
    cyc(1, 1, 32'h11, 0, 0, 0, 0);
    cyc(0, 1, 32'h22, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    chk("wcnt_retx", {24'b0, bsm_wcnt}, 32'd2);
    cyc(0, 0, 0, 1, 0, 0, 0);
    chk("retx_first_word", bsm_dout, 32'h11);
    idle(1);

    // Swap edges: write on swap counted, pending read dropped at swap.
    for (int i = 0; i < 3; i++) cyc(0, 1, 32'h5000_0000 + i, 0, 0, 0, 0);
    cyc(0, 1, 32'h5000_0003, 0, 0, 1, 0);
    chk("wcnt_swap_write", {24'b0, bsm_wcnt}, 32'd4);
    cyc(0, 1, 32'h6000_0000, 1, 0, 0, 0);
    cyc(0, 1, 32'h6000_0001, 0, 0, 1, 0);
    chk("pending_dropped_rdy", {31'b0, bsm_rdy}, 32'd1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("pending_dropped_no_rvalid", {31'b0, bsm_rvalid}, 32'd0);
    cyc(0, 1, 32'h7, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("midreset_wcnt", {24'b0, bsm_wcnt}, 32'd0);
    chk("midreset_empty", {31'b0, bsm_empty}, 32'd1);

    // Randomized traffic with irregular interval lengths.
    since = 0;
    gap = $urandom_range(20, 300);
    for (int n = 0; n < 4000; n++) begin
      bit tsco;
      tsco = (since >= gap);
      if (tsco) begin
        since = 0;
        gap = $urandom_range(10, 320);
      end else since++;
      cyc($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 55, $urandom,
          $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 4, tsco,
          $urandom_range(0, 999) < 2);
    end
    idle(4);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
